// File: rtl/addsub_pipelined_pkg.sv
// Shared sizing helpers for chunked carry-pipelined arithmetic.
// Used by the pipelined adder/subtractor and reusable by other chunked datapaths.
package addsub_pipelined_pkg;

   // Bits resolved per stage when WIDTH is spread over LATENCY stages.
   function automatic int unsigned chunk_width(input int unsigned width,
                                               input int unsigned latency);
      return (width + latency - 1) / latency;
   endfunction

   // Number of stages actually needed once the chunk size is fixed.
   function automatic int unsigned chunk_count(input int unsigned width,
                                               input int unsigned chunk);
      return (width + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/addsub_pipelined_if.sv
// Streaming operand/result bundle for the pipelined adder/subtractor.
// ce and in_valid are independent: a transaction is taken only when both are high.
interface addsub_pipelined_if #(
   parameter int unsigned WIDTH = 32
);
   logic             ce;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] q;
   logic             cout;
   logic             ovf;

   modport master (
      output ce, in_valid, a, b, sub, cin,
      input  out_valid, q, cout, ovf
   );

   modport slave (
      input  ce, in_valid, a, b, sub, cin,
      output out_valid, q, cout, ovf
   );
endinterface

// File: rtl/addsub_chunk_stage.sv
// One carry-pipeline stage: adds its chunk using the previous stage's registered carry,
// while the rest of the word rides along (sum bits below, operand bits above).
module addsub_chunk_stage #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CHUNK  = 8,
   parameter int unsigned IDX    = 0,
   parameter bit          IS_TOP = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce_i,
   input  logic             valid_i,
   input  logic             sub_i,
   input  logic             carry_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   output logic             sub_o,
   output logic             carry_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] b_o
);

   localparam int unsigned LO = IDX * CHUNK;
   localparam int unsigned HI = (LO + CHUNK > WIDTH) ? WIDTH : LO + CHUNK;
   localparam int unsigned CW = HI - LO;
   localparam int unsigned SW = CW + 1;

   logic [SW-1:0]    sum_c;
   logic [WIDTH-1:0] acc_d;
   logic             cap_c;
   logic             valid_q;
   logic             sub_q;
   logic             carry_q;
   logic [WIDTH-1:0] acc_q;
   logic             unused_b;

   // Data registers only move with a real transaction, so bubbles leave the last result in place.
   assign cap_c = ce_i & valid_i;

   always_comb begin
      sum_c = SW'(acc_i[HI-1:LO]) + SW'(b_i[HI-1:LO]) + SW'(carry_i);
      acc_d = acc_i;
      acc_d[HI-1:LO] = sum_c[CW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         acc_q   <= '0;
      end else if (ce_i) begin
         valid_q <= valid_i;
         if (valid_i) begin
            sub_q   <= sub_i;
            carry_q <= sum_c[CW];
            acc_q   <= acc_d;
         end
      end
   end

   assign valid_o = valid_q;
   assign sub_o   = sub_q;
   assign carry_o = carry_q;
   assign acc_o   = acc_q;

   // Upper b' bits still waiting for their stage; lower bits are already folded into acc.
   if (HI < WIDTH) begin : g_skew
      logic [WIDTH-HI-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            b_q <= '0;
         end else if (cap_c) begin
            b_q <= b_i[WIDTH-1:HI];
         end
      end
      assign b_o = {b_q, HI'(0)};
   end else begin : g_no_skew
      assign b_o = '0;
   end

   // Top stage owns the word MSB, so it forms the externally visible flags.
   if (IS_TOP) begin : g_flags
      logic cmsb_c;
      logic cout_q;
      logic ovf_q;
      assign cmsb_c = acc_i[HI-1] ^ b_i[HI-1] ^ sum_c[CW-1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (cap_c) begin
            cout_q <= sum_c[CW] ^ sub_i;
            ovf_q  <= cmsb_c ^ sum_c[CW];
         end
      end
      assign cout_o = cout_q;
      assign ovf_o  = ovf_q;
   end else begin : g_no_flags
      assign cout_o = 1'b0;
      assign ovf_o  = 1'b0;
   end

   assign unused_b = ^b_i;

endmodule

// File: rtl/addsub_pipelined.sv
// Streaming pipelined adder/subtractor: one chunk of the carry chain resolves per stage,
// accepting one operand pair per enabled cycle with latency equal to the stage count.
module addsub_pipelined
   import addsub_pipelined_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 4
) (
   input logic                clk,
   input logic                rst_n,
   addsub_pipelined_if.slave  bus
);

   localparam int unsigned CHUNK  = chunk_width(WIDTH, LATENCY);
   localparam int unsigned STAGES = chunk_count(WIDTH, CHUNK);

   logic [STAGES:0]            valid_s;
   logic [STAGES:0]            sub_s;
   logic [STAGES:0]            carry_s;
   logic [STAGES-1:0]          cout_s;
   logic [STAGES-1:0]          ovf_s;
   logic [STAGES:0][WIDTH-1:0] acc_s;
   logic [STAGES:0][WIDTH-1:0] b_s;
   logic                       unused_tail;

   // Subtraction is a + ~b + 1; a borrow-in simply removes that +1.
   assign valid_s[0] = bus.in_valid;
   assign sub_s[0]   = bus.sub;
   assign carry_s[0] = bus.cin ^ bus.sub;
   assign acc_s[0]   = bus.a;
   assign b_s[0]     = bus.sub ? ~bus.b : bus.b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      addsub_chunk_stage #(
         .WIDTH  (WIDTH),
         .CHUNK  (CHUNK),
         .IDX    (k),
         .IS_TOP (k == STAGES - 1)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .ce_i    (bus.ce),
         .valid_i (valid_s[k]),
         .sub_i   (sub_s[k]),
         .carry_i (carry_s[k]),
         .acc_i   (acc_s[k]),
         .b_i     (b_s[k]),
         .valid_o (valid_s[k+1]),
         .sub_o   (sub_s[k+1]),
         .carry_o (carry_s[k+1]),
         .cout_o  (cout_s[k]),
         .ovf_o   (ovf_s[k]),
         .acc_o   (acc_s[k+1]),
         .b_o     (b_s[k+1])
      );
   end

   assign bus.out_valid = valid_s[STAGES];
   assign bus.q         = acc_s[STAGES];
   assign bus.cout      = cout_s[STAGES-1];
   assign bus.ovf       = ovf_s[STAGES-1];

   // Tail-stage chain signals and lower-stage flag stubs have no consumer.
   assign unused_tail = ^{sub_s[STAGES], carry_s[STAGES], b_s[STAGES], cout_s, ovf_s};

endmodule

// File: tb/tb_addsub_pipelined.sv
// Scoreboard bench for addsub_pipelined: four configurations share one stimulus stream
// and are compared against a plain-integer reference model.
module tb_addsub_pipelined;

   localparam int NDUT = 4;
   localparam int unsigned W   [NDUT] = '{8, 10, 3, 7};
   localparam int unsigned STG [NDUT] = '{4, 4, 3, 1};

   typedef struct packed {
      logic [63:0] q;
      logic        cout;
      logic        ovf;
      logic [31:0] due;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        ce_drv, inv_drv, sub_drv, cin_drv;
   logic [63:0] a_drv, b_drv;

   int          n_checks;
   int          n_errors;
   logic [31:0] en_cnt;
   res_t        sb      [NDUT][$];
   res_t        hold    [NDUT];
   logic        hold_ov [NDUT];
   logic        seen    [NDUT];

   logic [63:0] q_obs [NDUT];
   logic [NDUT-1:0] ov_obs, co_obs, of_obs;

   addsub_pipelined_if #(.WIDTH(8))  bus0 ();
   addsub_pipelined_if #(.WIDTH(10)) bus1 ();
   addsub_pipelined_if #(.WIDTH(3))  bus2 ();
   addsub_pipelined_if #(.WIDTH(7))  bus3 ();

   addsub_pipelined #(.WIDTH(8),  .LATENCY(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   addsub_pipelined #(.WIDTH(10), .LATENCY(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   addsub_pipelined #(.WIDTH(3),  .LATENCY(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   addsub_pipelined #(.WIDTH(7),  .LATENCY(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   assign bus0.ce = ce_drv; assign bus0.in_valid = inv_drv; assign bus0.sub = sub_drv; assign bus0.cin = cin_drv;
   assign bus1.ce = ce_drv; assign bus1.in_valid = inv_drv; assign bus1.sub = sub_drv; assign bus1.cin = cin_drv;
   assign bus2.ce = ce_drv; assign bus2.in_valid = inv_drv; assign bus2.sub = sub_drv; assign bus2.cin = cin_drv;
   assign bus3.ce = ce_drv; assign bus3.in_valid = inv_drv; assign bus3.sub = sub_drv; assign bus3.cin = cin_drv;
   assign bus0.a = a_drv[7:0]; assign bus0.b = b_drv[7:0];
   assign bus1.a = a_drv[9:0]; assign bus1.b = b_drv[9:0];
   assign bus2.a = a_drv[2:0]; assign bus2.b = b_drv[2:0];
   assign bus3.a = a_drv[6:0]; assign bus3.b = b_drv[6:0];

   assign q_obs[0] = 64'(bus0.q); assign ov_obs[0] = bus0.out_valid; assign co_obs[0] = bus0.cout; assign of_obs[0] = bus0.ovf;
   assign q_obs[1] = 64'(bus1.q); assign ov_obs[1] = bus1.out_valid; assign co_obs[1] = bus1.cout; assign of_obs[1] = bus1.ovf;
   assign q_obs[2] = 64'(bus2.q); assign ov_obs[2] = bus2.out_valid; assign co_obs[2] = bus2.cout; assign of_obs[2] = bus2.ovf;
   assign q_obs[3] = 64'(bus3.q); assign ov_obs[3] = bus3.out_valid; assign co_obs[3] = bus3.cout; assign of_obs[3] = bus3.ovf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic string tg(input string name, input int d);
      return $sformatf("dut%0d_%s", d, name);
   endfunction

   // Reference: whole-word arithmetic, carry into MSB taken from the (w-1)-bit low sum.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic ci, input int unsigned w);
      res_t        r;
      logic [63:0] m, bb, full, low;
      logic        c0, co, cm;
      m    = (64'd1 << w) - 64'd1;
      bb   = (s ? ~b : b) & m;
      c0   = ci ^ s;
      full = (a & m) + bb + 64'(c0);
      low  = (a & (m >> 1)) + (bb & (m >> 1)) + 64'(c0);
      co   = full[w];
      cm   = low[w-1];
      r.q    = full & m;
      r.cout = co ^ s;
      r.ovf  = cm ^ co;
      r.due  = '0;
      return r;
   endfunction

   // Monitor: capture inputs at the edge, check outputs 1 time unit later.
   always @(posedge clk) begin
      logic        r_s, c_s, v_s, s_s, ci_s, exp_ov;
      logic [63:0] a_s, b_s;
      res_t        e;
      r_s = rst_n; c_s = ce_drv; v_s = inv_drv; s_s = sub_drv; ci_s = cin_drv;
      a_s = a_drv; b_s = b_drv;
      #1;
      if (r_s) begin
         if (c_s) en_cnt = en_cnt + 32'd1;
         for (int d = 0; d < NDUT; d++) begin
            if (c_s) begin
               if (v_s) begin
                  e = model(a_s, b_s, s_s, ci_s, W[d]);
                  e.due = en_cnt + STG[d] - 32'd1;
                  sb[d].push_back(e);
               end
               exp_ov = (sb[d].size() != 0) && (sb[d][0].due == en_cnt);
               if (exp_ov) begin
                  hold[d] = sb[d].pop_front();
                  seen[d] = 1'b1;
               end
               hold_ov[d] = exp_ov;
            end
            check_val(tg(c_s ? "out_valid" : "stall_out_valid", d), 64'(ov_obs[d]), 64'(hold_ov[d]));
            if (hold_ov[d]) begin
               check_val(tg("q", d), q_obs[d], hold[d].q);
               check_val(tg("cout", d), 64'(co_obs[d]), 64'(hold[d].cout));
               check_val(tg("ovf", d), 64'(of_obs[d]), 64'(hold[d].ovf));
            end else if (!seen[d]) begin
               check_val(tg("q_before_first", d), q_obs[d], 64'd0);
               check_val(tg("flags_before_first", d), 64'({co_obs[d], of_obs[d]}), 64'd0);
            end
         end
      end
   end

   task automatic drive(input logic c, input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic ci);
      @(negedge clk);
      ce_drv = c; inv_drv = v; a_drv = a; b_drv = b; sub_drv = s; cin_drv = ci;
   endtask

   // Enabled cycles with no transaction; bubble data is deliberately random.
   task automatic idle(input int n);
      repeat (n) drive(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic stall(input int n);
      repeat (n) drive(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      inv_drv = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
         sb[d].delete();
         seen[d]    = 1'b0;
         hold_ov[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         check_val(tg("rst_out_valid", d), 64'(ov_obs[d]), 64'd0);
         check_val(tg("rst_q", d), q_obs[d], 64'd0);
         check_val(tg("rst_flags", d), 64'({co_obs[d], of_obs[d]}), 64'd0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; en_cnt = '0;
      rst_n = 1'b0; ce_drv = 1'b0; inv_drv = 1'b0; sub_drv = 1'b0; cin_drv = 1'b0;
      a_drv = '0; b_drv = '0;
      for (int d = 0; d < NDUT; d++) begin
         seen[d] = 1'b0; hold_ov[d] = 1'b0; hold[d] = '0;
      end
      apply_reset();
      idle(3);

      // Isolated corner cases: carry wrap, borrow, positive and negative overflow.
      drive(1'b1, 1'b1, 64'hFF,  64'h01, 1'b0, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h00,  64'h01, 1'b1, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h7F,  64'h01, 1'b0, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h80,  64'h01, 1'b1, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h3FF, 64'h01, 1'b0, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h3,   64'h5,  1'b0, 1'b0); idle(6);
      drive(1'b1, 1'b1, 64'h00,  64'h00, 1'b1, 1'b1); idle(6);

      // Back-to-back stream with one bubble slot.
      drive(1'b1, 1'b1, 64'h01, 64'h02, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 64'h10, 64'h03, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 64'hF0, 64'h20, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 64'hAA, 64'h55, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 64'h05, 64'h05, 1'b1, 1'b0);
      idle(8);

      // Stall with two in flight, then stall again while a result is presented.
      drive(1'b1, 1'b1, 64'h12, 64'h34, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 64'h56, 64'h9A, 1'b1, 1'b1);
      stall(3);
      idle(2);
      stall(2);
      idle(8);

      // Reset with transactions in flight.
      drive(1'b1, 1'b1, 64'h21, 64'h43, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 64'h65, 64'h87, 1'b1, 1'b0);
      idle(1);
      apply_reset();
      idle(10);

      // Random regression with random stalls and bubbles.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
               {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      idle(12);

      for (int d = 0; d < NDUT; d++) begin
         check_val(tg("drain", d), 64'(sb[d].size()), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
